// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: FSM state encoding, SPI mode values
// and the bit positions of CPOL/CPHA inside a 2-bit mode word.
package spi_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

endpackage

// File: rtl/spi_sclk_tick.sv
// Half-period tick generator: one-cycle tick every CLK_DIV cycles while en is
// high; the count is held at zero while en is low so it restarts on en rising.
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_mode_tx.sv
// Full-duplex SPI master supporting all four CPOL/CPHA modes; one DATA_W-bit
// word per start pulse, MSB first in both directions.
module spi_master_mode_tx
  import spi_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] din,
  input  logic              miso,
  output logic              sclk,
  output logic              cs,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data
);

  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              sclk_q, sclk_d;
  logic              cs_q, cs_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick, tick_en;

  assign tick_en = (state_q == ST_SETUP) || (state_q == ST_XFER) || (state_q == ST_HOLD);

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        sclk_d = mode[CPOL_BIT];
        if (start) begin
          state_d = ST_SETUP;
          mode_d  = mode;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          edge_d  = '0;
          rx_sr_d = '0;
          // CPHA=0 presents the MSB during setup, so the shifter starts one bit ahead
          tx_sr_d = mode[CPHA_BIT] ? din : (din << 1);
          mosi_d  = mode[CPHA_BIT] ? 1'b0 : din[DATA_W-1];
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (edge_q == LAST_EDGE) begin
            state_d = ST_HOLD;
          end else begin
            edge_d = edge_q + 1'b1;
          end
          // even edge index = leading clock edge
          if (!edge_q[0]) begin
            if (mode_q[CPHA_BIT]) begin
              mosi_d  = tx_sr_q[DATA_W-1];
              tx_sr_d = tx_sr_q << 1;
            end else begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            end
          end else begin
            if (mode_q[CPHA_BIT]) begin
              rx_sr_d = {rx_sr_q[DATA_W-2:0], miso};
            end else if (edge_q != LAST_EDGE) begin
              mosi_d  = tx_sr_q[DATA_W-1];
              tx_sr_d = tx_sr_q << 1;
            end
          end
        end
      end
      ST_HOLD: begin
        sclk_d = mode_q[CPOL_BIT];
        if (tick) begin
          state_d   = ST_DONE;
          cs_d      = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        sclk_d  = mode_q[CPOL_BIT];
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_mode_tx.sv
// Loopback bench for the SPI master: an 8-bit/div-4 instance for the mode
// table and corner sequences, and a 16-bit/div-1 instance for the fast case.
module tb_spi_master_mode_tx;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance A: DATA_W=8, CLK_DIV=4
  logic       start_a = 1'b0;
  logic [1:0] mode_a  = 2'b00;
  logic [7:0] din_a   = 8'h00;
  logic       miso_a;
  logic       sclk_a, cs_a, mosi_a, busy_a, done_a;
  logic [7:0] rx_a;
  assign miso_a = mosi_a;

  // instance B: DATA_W=16, CLK_DIV=1
  logic        start_b = 1'b0;
  logic [1:0]  mode_b  = 2'b00;
  logic [15:0] din_b   = 16'h0000;
  logic        miso_b;
  logic        sclk_b, cs_b, mosi_b, busy_b, done_b;
  logic [15:0] rx_b;
  assign miso_b = mosi_b;

  spi_master_mode_tx #(.DATA_W(8), .CLK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .din(din_a),
    .miso(miso_a), .sclk(sclk_a), .cs(cs_a), .mosi(mosi_a),
    .busy(busy_a), .done(done_a), .rx_data(rx_a)
  );

  spi_master_mode_tx #(.DATA_W(16), .CLK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .din(din_b),
    .miso(miso_b), .sclk(sclk_b), .cs(cs_b), .mosi(mosi_b),
    .busy(busy_b), .done(done_b), .rx_data(rx_b)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // bus monitor for instance A: counts sclk edges while cs is low and
  // collects mosi on the edges where the slave would sample it
  int         edges    = 0;
  int         done_cnt = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_cs   = 1'b1;
  logic [7:0] mosi_bits = 8'h00;
  logic       cur_cpha  = 1'b0;

  always @(negedge clk) begin
    if (done_a) done_cnt <= done_cnt + 1;
    if (prev_cs && !cs_a) begin
      edges     <= 0;
      mosi_bits <= 8'h00;
    end else if (!cs_a && (sclk_a !== prev_sclk)) begin
      edges <= edges + 1;
      if (edges[0] == cur_cpha) mosi_bits <= {mosi_bits[6:0], mosi_a};
    end
    prev_sclk <= sclk_a;
    prev_cs   <= cs_a;
  end

  typedef struct {
    logic [7:0] rx;
    int         edges;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[6];

  // one transfer on instance A; done must appear at k = N+1 = 73 cycles after start
  task automatic run_xfer(input logic [1:0] m, input logic [7:0] d,
                          input bit protect, input bit start_in_done);
    int         lat;
    bit         got;
    exp_t       e;
    logic [7:0] rx_before;
    rx_before = rx_a;
    cur_cpha  = m[0];
    mode_a    = m;
    din_a     = d;
    start_a   = 1'b1;
    sb_q.push_back('{rx: d, edges: 16});
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 200 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start_a = 1'b0;
        mode_a  = ~m;
        din_a   = ~d;
        check("busy_after_start", busy_a, 1);
        check("cs_low_after_start", cs_a, 0);
      end
      if (protect && k == 20) begin
        start_a = 1'b1;
        din_a   = 8'h11;
      end
      if (protect && k == 21) start_a = 1'b0;
      if (protect && k == 40) check("rx_stable_mid", rx_a, rx_before);
      if (done_a) begin
        got = 1'b1;
        lat = k;
        e   = sb_q.pop_front();
        check("done_latency", lat, 73);
        check("rx_data", rx_a, e.rx);
        check("edge_count", edges, e.edges);
        check("mosi_bits", mosi_bits, d);
        check("cs_high_at_done", cs_a, 1);
        check("busy_low_at_done", busy_a, 0);
        if (start_in_done) start_a = 1'b1;
      end
    end
    if (!got) begin
      check("done_timeout", 0, 1);
      void'(sb_q.pop_front());
    end else begin
      @(posedge clk); #1;
      start_a = 1'b0;
      check("done_single_cycle", done_a, 0);
      check("sclk_idle_after", sclk_a, m[1]);
      if (start_in_done) begin
        check("start_in_done_ignored_busy", busy_a, 0);
        check("start_in_done_ignored_cs", cs_a, 1);
      end
    end
    mode_a = m;
    $display("xfer A mode=%0d din=%02h rx=%02h edges=%0d latency=%0d", m, d, rx_a, edges, lat);
  endtask

  task automatic run_b(input logic [1:0] m, input logic [15:0] d);
    int lat;
    bit got;
    mode_b  = m;
    din_b   = d;
    start_b = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 100 && !got; k++) begin
      @(posedge clk); #1;
      if (k == 1) start_b = 1'b0;
      if (done_b) begin
        got = 1'b1;
        lat = k;
        check("b_done_latency", lat, 35);
        check("b_rx_data", rx_b, d);
      end
    end
    if (!got) check("b_done_timeout", 0, 1);
    $display("xfer B mode=%0d din=%04h rx=%04h latency=%0d", m, d, rx_b, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dc0;
    bit hit;

    vecs[0] = '{mode: SPI_MODE0, din: 8'hA5, exp_rx: 8'hA5};
    vecs[1] = '{mode: SPI_MODE1, din: 8'h3C, exp_rx: 8'h3C};
    vecs[2] = '{mode: SPI_MODE2, din: 8'h3C, exp_rx: 8'h3C};
    vecs[3] = '{mode: SPI_MODE3, din: 8'h3C, exp_rx: 8'h3C};
    vecs[4] = '{mode: SPI_MODE0, din: 8'h5A, exp_rx: 8'h5A};
    vecs[5] = '{mode: SPI_MODE3, din: 8'h81, exp_rx: 8'h81};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs_a, 1);
    check("rst_sclk", sclk_a, 0);
    check("rst_mosi", mosi_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rx", rx_a, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // mode table
    for (int i = 0; i < 6; i++) begin
      mode_a = vecs[i].mode;
      repeat (2) @(posedge clk);
      #1;
      check("sclk_idle_before", sclk_a, vecs[i].mode[1]);
      run_xfer(vecs[i].mode, vecs[i].din, 1'b0, 1'b0);
      check("table_rx", rx_a, vecs[i].exp_rx);
      repeat (2) @(posedge clk);
      #1;
    end

    // start and mode change while busy
    dc0 = done_cnt;
    run_xfer(SPI_MODE0, 8'h96, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("protect_single_done", done_cnt - dc0, 1);
    check("protect_idle_busy", busy_a, 0);

    // reset in the middle of a transfer
    cur_cpha = 1'b0;
    mode_a   = SPI_MODE0;
    din_a    = 8'h55;
    start_a  = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    dc0 = done_cnt;
    hit = 1'b0;
    for (int k = 0; k < 300 && !hit; k++) begin
      @(negedge clk); #1;
      if (edges == 7) hit = 1'b1;
    end
    check("reached_edge7", hit, 1);
    rst = 1'b0;
    #1;
    check("midrst_cs", cs_a, 1);
    check("midrst_sclk", sclk_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_rx", rx_a, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    check("midrst_no_done", done_cnt - dc0, 0);
    $display("xfer A mid-transfer reset, done pulses=%0d", done_cnt - dc0);
    run_xfer(SPI_MODE0, 8'hFF, 1'b0, 1'b0);

    // back to back, with a start pulse in the done cycle that must be ignored
    repeat (2) @(posedge clk);
    #1;
    run_xfer(SPI_MODE0, 8'h01, 1'b0, 1'b1);
    run_xfer(SPI_MODE0, 8'h80, 1'b0, 1'b0);

    // 16-bit word with the fastest divider
    run_b(SPI_MODE0, 16'hBEEF);
    repeat (2) @(posedge clk);
    #1;
    run_b(SPI_MODE3, 16'h8001);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
